// File: rtl/instr_fetch_if.sv
// Fetch-to-decode instruction handshake: registered instruction, its address,
// and a valid/ready pair.
interface instr_fetch_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;

    modport master (output instr, output instr_pc, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_pc, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues PC-driven reads to a 1-cycle synchronous
// memory and delivers results in order through a 2-entry output/skid buffer.
module instr_fetch #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  prog_ctr,
    output logic          nextFlag,
    input  logic          jump_taken,
    input  logic          halt,
    output logic          mem_rd_en,
    output logic [D-1:0]  mem_addr,
    input  logic [W-1:0]  mem_rdata,
    instr_fetch_if.master dec,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t       state, state_next;
    logic         pending;
    logic [D-1:0] pending_pc;
    logic         skid_valid;
    logic [W-1:0] skid_instr;
    logic [D-1:0] skid_pc;
    logic [1:0]   occ;
    logic         consume;
    logic         issue;

    assign consume = dec.instr_valid && dec.instr_ready;
    assign occ     = {1'b0, dec.instr_valid} + {1'b0, skid_valid} + {1'b0, pending};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // consume implies instr_valid, so occ - consume cannot underflow
    always_comb begin
        issue     = (state == FETCH) && !halt && !jump_taken &&
                    ((occ - {1'b0, consume}) < 2'd2);
        nextFlag  = issue;
        mem_rd_en = issue;
        mem_addr  = prog_ctr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending         <= 1'b0;
            pending_pc      <= '0;
            skid_valid      <= 1'b0;
            skid_instr      <= '0;
            skid_pc         <= '0;
            dec.instr       <= '0;
            dec.instr_pc    <= '0;
            dec.instr_valid <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= (state == HALTED) && (occ == 2'd0);
            if (jump_taken) begin
                pending         <= 1'b0;
                skid_valid      <= 1'b0;
                dec.instr_valid <= 1'b0;
            end else begin
                pending <= issue;
                if (issue) pending_pc <= prog_ctr;
                if (consume || !dec.instr_valid) begin
                    // skid is older than the returning word, so it leaves first
                    if (skid_valid) begin
                        dec.instr       <= skid_instr;
                        dec.instr_pc    <= skid_pc;
                        dec.instr_valid <= 1'b1;
                        skid_valid      <= pending;
                        if (pending) begin
                            skid_instr <= mem_rdata;
                            skid_pc    <= pending_pc;
                        end
                    end else begin
                        dec.instr_valid <= pending;
                        if (pending) begin
                            dec.instr    <= mem_rdata;
                            dec.instr_pc <= pending_pc;
                        end
                    end
                end else if (pending) begin
                    skid_valid <= 1'b1;
                    skid_instr <= mem_rdata;
                    skid_pc    <= pending_pc;
                end
            end
        end
    end
endmodule
